// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one simple-FIFO write port between NREQ requesters.
// Round-robin arbitration with packet locking. The granted requester keeps the
// port until its last word, or until MAX_BURST words have moved in this grant.
// The block is a sequencer only. Data passes combinationally from the owner's
// slice to the FIFO, and nothing is stored here.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no owner; search req_valid from rr_ptr and register the winner
// LOCK   | owner holds the FIFO port; words move whenever fifo_unfull is high
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 16,
  parameter int MAX_BURST = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_last,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic              fifo_w_req,
  input  logic              fifo_unfull,
  output logic [DW-1:0]      fifo_data,
  output logic [NREQ-1:0]    grant_vec,
  output logic              busy,
  output logic [7:0]        burst_cnt,
  output logic              forced_rel
);

  localparam int         PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] CAP = 8'(MAX_BURST);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   rr_ptr_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic [7:0]      burst_cnt_nxt;
  logic            forced_rel_nxt;

  logic [PW-1:0]   owner;
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic            owner_valid;
  logic            owner_last;
  logic            xfer;
  logic            cap_hit;
  logic [7:0]      cnt_inc;

  // Convert the one-hot grant into an owner index. It is 0 when no grant is held.
  always_comb begin
    owner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_vec[i]) owner = PW'(i);
    end
  end

  // Round-robin search. Scan from rr_ptr, wrap modulo NREQ, and take the first valid requester.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  // Zero-bubble data path. The owner's slice goes straight to the FIFO, and the output is 0 when idle.
  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_vec[i]) fifo_data = req_data[i*DW +: DW];
    end
  end

  // Handshake toward the requesters and the FIFO. Only the owner ever sees ready.
  always_comb begin
    busy        = (state == S_LOCK);
    owner_valid = |(req_valid & grant_vec);
    owner_last  = |(req_last & grant_vec);
    req_ready   = busy ? (grant_vec & {NREQ{fifo_unfull}}) : '0;
    fifo_w_req  = busy & owner_valid & fifo_unfull;
    xfer        = fifo_w_req;
    cnt_inc     = burst_cnt + 8'd1;
    cap_hit     = (cnt_inc == CAP);
  end

  // Next-state logic: grant, burst count, release and round-robin pointer.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_vec;
    rr_ptr_nxt     = rr_ptr;
    burst_cnt_nxt  = burst_cnt;
    forced_rel_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          grant_nxt     = NREQ'(1) << win_idx;
          burst_cnt_nxt = 8'd0;
          state_nxt     = S_LOCK;
        end
      end
      S_LOCK: begin
        if (xfer) begin
          burst_cnt_nxt = cnt_inc;
          if (owner_last || cap_hit) begin
            grant_nxt      = '0;
            state_nxt      = S_IDLE;
            rr_ptr_nxt     = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
            // A last word that lands exactly on the cap is a normal release.
            forced_rel_nxt = !owner_last;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // State register. Reset acts immediately and does not wait for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      grant_vec  <= '0;
      rr_ptr     <= '0;
      burst_cnt  <= 8'd0;
      forced_rel <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant_vec  <= grant_nxt;
      rr_ptr     <= rr_ptr_nxt;
      burst_cnt  <= burst_cnt_nxt;
      forced_rel <= forced_rel_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with NREQ=4, DW=16 and MAX_BURST=4.
// Inputs change 1 ns after the rising edge. Outputs are sampled on the falling edge.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int MB   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic              fifo_w_req;
  logic              fifo_unfull;
  logic [DW-1:0]      fifo_data;
  logic [NREQ-1:0]    grant_vec;
  logic              busy;
  logic [7:0]        burst_cnt;
  logic              forced_rel;

  int checks   = 0;
  int failures = 0;
  int w;
  int bw;
  int exp_g;
  logic [3:0] g1h;
  logic       pat [6];

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_w_req (fifo_w_req),
    .fifo_unfull(fifo_unfull),
    .fifo_data  (fifo_data),
    .grant_vec  (grant_vec),
    .busy       (busy),
    .burst_cnt  (burst_cnt),
    .forced_rel (forced_rel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_port(input string tag, input logic [3:0] g, input logic wr,
                          input logic [15:0] d, input logic [3:0] rdy);
    chk({tag, ".grant"}, 32'(grant_vec), 32'(g));
    chk({tag, ".w_req"}, 32'(fifo_w_req), 32'(wr));
    chk({tag, ".data"},  32'(fifo_data),  32'(d));
    chk({tag, ".ready"}, 32'(req_ready),  32'(rdy));
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [15:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  // Requester 1 streams n words B000+w, with last on word 9. Words move every cycle.
  task automatic stream_r1(input int n);
    for (int j = 0; j < n; j++) begin
      set_data(1, 16'hB000 + 16'(w));
      req_last[1] = (w == 9);
      @(negedge clk);
      chk_port("cap_word", 4'b0010, 1'b1, 16'hB000 + 16'(w), 4'b0010);
      chk("cap_cnt", 32'(burst_cnt), 32'(j));
      next();
      w++;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'b1111; req_last = 4'b0000;
    req_data = {16'h3333, 16'h2222, 16'h1111, 16'h0000}; fifo_unfull = 1'b1;
    w = 0; bw = 0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1; pat[5] = 1'b1;

    // Reset values. Requests are present, but nothing may be granted.
    #2;
    chk_port("rst", 4'b0000, 1'b0, 16'h0000, 4'b0000);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.cnt", 32'(burst_cnt), 32'd0);
    chk("rst.forced", 32'(forced_rel), 32'd0);
    next(); next();
    rst = 1'b0; req_valid = 4'b0000;

    // Requester 2 sends a 3-word packet.
    req_valid = 4'b0100; set_data(2, 16'h2000);
    @(negedge clk); chk_port("s1_arb", 4'b0000, 1'b0, 16'h0000, 4'b0000);
    next();
    @(negedge clk); chk_port("s1_w0", 4'b0100, 1'b1, 16'h2000, 4'b0100);
    chk("s1_w0.cnt", 32'(burst_cnt), 32'd0); chk("s1_w0.busy", 32'(busy), 32'd1);
    next(); set_data(2, 16'h2001);
    @(negedge clk); chk_port("s1_w1", 4'b0100, 1'b1, 16'h2001, 4'b0100);
    chk("s1_w1.cnt", 32'(burst_cnt), 32'd1);
    next(); set_data(2, 16'h2002); req_last = 4'b0100;
    @(negedge clk); chk_port("s1_w2", 4'b0100, 1'b1, 16'h2002, 4'b0100);
    next(); req_valid = 4'b0000; req_last = 4'b0000;
    @(negedge clk); chk_port("s1_idle", 4'b0000, 1'b0, 16'h0000, 4'b0000);
    chk("s1_idle.cnt", 32'(burst_cnt), 32'd3); chk("s1_idle.forced", 32'(forced_rel), 32'd0);
    next();

    // Contention with 1-word packets. rr_ptr is 3, so the order is 3,0,1,2,3.
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_data(i, 16'hA000 + 16'(i));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); chk("cont_gap.grant", 32'(grant_vec), 32'd0);
      next();
      exp_g = (3 + k) % NREQ; g1h = 4'b0001 << exp_g;
      @(negedge clk); chk_port("cont_lock", g1h, 1'b1, 16'hA000 + 16'(exp_g), g1h);
      next();
    end
    req_valid = 4'b0000; req_last = 4'b0000;

    // Burst cap. Requester 1 sends 10 words while requester 3 has one 1-word packet pending.
    req_valid = 4'b1010; req_last = 4'b1000; set_data(3, 16'hC003); w = 0;
    @(negedge clk); chk("cap_arb.grant", 32'(grant_vec), 32'd0);
    next();
    stream_r1(4);
    @(negedge clk); chk("cap1.grant", 32'(grant_vec), 32'd0);
    chk("cap1.forced", 32'(forced_rel), 32'd1); chk("cap1.cnt", 32'(burst_cnt), 32'd4);
    next();
    @(negedge clk); chk_port("cap_r3", 4'b1000, 1'b1, 16'hC003, 4'b1000);
    chk("cap_r3.forced", 32'(forced_rel), 32'd0);
    next(); req_valid = 4'b0010; req_last[3] = 1'b0;
    @(negedge clk); chk("cap_gap.grant", 32'(grant_vec), 32'd0);
    chk("cap_gap.forced", 32'(forced_rel), 32'd0);
    next();
    stream_r1(4);
    @(negedge clk); chk("cap2.forced", 32'(forced_rel), 32'd1);
    next();
    stream_r1(2);
    @(negedge clk); chk("cap3.grant", 32'(grant_vec), 32'd0);
    chk("cap3.forced", 32'(forced_rel), 32'd0); chk("cap3.cnt", 32'(burst_cnt), 32'd2);
    req_valid = 4'b0000; req_last = 4'b0000;
    next();

    // Back-pressure. Requester 0 sends 4 words while fifo_unfull follows 1,0,0,1,1,1.
    req_valid = 4'b0001; set_data(0, 16'hD000);
    @(negedge clk); chk("bp_arb.grant", 32'(grant_vec), 32'd0);
    next();
    for (int c = 0; c < 6; c++) begin
      fifo_unfull = pat[c];
      set_data(0, 16'hD000 + 16'(bw));
      req_last[0] = (bw == 3);
      @(negedge clk);
      chk_port("bp", 4'b0001, pat[c], 16'hD000 + 16'(bw), pat[c] ? 4'b0001 : 4'b0000);
      chk("bp.cnt", 32'(burst_cnt), 32'(bw));
      next();
      if (pat[c]) bw++;
    end
    fifo_unfull = 1'b1; req_valid = 4'b0000; req_last = 4'b0000;
    @(negedge clk); chk("bp_end.grant", 32'(grant_vec), 32'd0);
    chk("bp_end.cnt", 32'(burst_cnt), 32'd4); chk("bp_end.forced", 32'(forced_rel), 32'd0);
    next();

    // Owner stall. Requester 0 drops valid mid-packet while requester 3 waits.
    req_valid = 4'b0001; set_data(0, 16'hE000);
    @(negedge clk); chk("st_arb.grant", 32'(grant_vec), 32'd0);
    next();
    @(negedge clk); chk_port("st_w0", 4'b0001, 1'b1, 16'hE000, 4'b0001);
    next();
    req_valid = 4'b1000; req_last = 4'b1000; set_data(3, 16'hE003);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk); chk_port("st_hold", 4'b0001, 1'b0, 16'hE000, 4'b0001);
      chk("st_hold.cnt", 32'(burst_cnt), 32'd1);
      next();
    end
    req_valid = 4'b1001; req_last = 4'b1001; set_data(0, 16'hE001);
    @(negedge clk); chk_port("st_last", 4'b0001, 1'b1, 16'hE001, 4'b0001);
    next(); req_valid = 4'b1000;
    @(negedge clk); chk("st_gap.grant", 32'(grant_vec), 32'd0);
    next();
    @(negedge clk); chk_port("st_r3", 4'b1000, 1'b1, 16'hE003, 4'b1000);
    next(); req_valid = 4'b0000; req_last = 4'b0000;

    // Move rr_ptr away from 0 with a 1-word packet from requester 1.
    req_valid = 4'b0010; req_last = 4'b0010; set_data(1, 16'hF001);
    @(negedge clk); chk("pre_arb.grant", 32'(grant_vec), 32'd0);
    next();
    @(negedge clk); chk_port("pre_r1", 4'b0010, 1'b1, 16'hF001, 4'b0010);
    next(); req_valid = 4'b0000; req_last = 4'b0000;

    // Reset mid-burst. Requester 2 sends a 5-word packet, and reset arrives after word 2.
    req_valid = 4'b0100; set_data(2, 16'h2100);
    @(negedge clk); chk("rm_arb.grant", 32'(grant_vec), 32'd0);
    next();
    @(negedge clk); chk_port("rm_w0", 4'b0100, 1'b1, 16'h2100, 4'b0100);
    next(); set_data(2, 16'h2101);
    @(negedge clk); chk_port("rm_w1", 4'b0100, 1'b1, 16'h2101, 4'b0100);
    next(); set_data(2, 16'h2102);
    #2 rst = 1'b1;
    #1;
    chk_port("rm_async", 4'b0000, 1'b0, 16'h0000, 4'b0000);
    chk("rm_async.busy", 32'(busy), 32'd0); chk("rm_async.cnt", 32'(burst_cnt), 32'd0);
    next(); rst = 1'b0;

    // After reset, arbitration restarts from 0 with the order 0,1,2,3,0.
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_data(i, 16'hA000 + 16'(i));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); chk("post_gap.grant", 32'(grant_vec), 32'd0);
      next();
      exp_g = k % NREQ; g1h = 4'b0001 << exp_g;
      @(negedge clk); chk_port("post_lock", g1h, 1'b1, 16'hA000 + 16'(exp_g), g1h);
      next();
    end
    req_valid = 4'b0000; req_last = 4'b0000;
    next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
